// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 3-stage radix-2 FFT pipeline.
// Reads one frame of N = 2**logn complex samples from a source buffer and
// streams them into the FFT one per cycle. Captures the FFT output stream
// into a destination buffer in arrival order, then pulses done. A drain
// watchdog aborts the frame (sticky error) if the FFT stops producing
// results.
module fft_frame_ctrl #(
    parameter int FLOAT_PRECISION = 64,
    parameter int logn            = 8,
    parameter int TIMEOUT         = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,

    output logic                       src_rd_en,
    output logic [logn-1:0]            src_addr,
    input  logic [FLOAT_PRECISION-1:0] src_re,
    input  logic [FLOAT_PRECISION-1:0] src_im,

    output logic                       fft_in_valid,
    output logic [FLOAT_PRECISION-1:0] fft_fi_re,
    output logic [FLOAT_PRECISION-1:0] fft_fi_im,

    input  logic                       fft_out_valid,
    input  logic [FLOAT_PRECISION-1:0] fft_fo_re,
    input  logic [FLOAT_PRECISION-1:0] fft_fo_im,

    output logic                       dst_wr_en,
    output logic [logn-1:0]            dst_addr,
    output logic [FLOAT_PRECISION-1:0] dst_re,
    output logic [FLOAT_PRECISION-1:0] dst_im
);

    // Counters are one bit wider than the addresses so they can hold N itself.
    localparam logic [logn:0] N_CNT   = {1'b1, {logn{1'b0}}};
    localparam logic [logn:0] LAST_RD = N_CNT - 1'b1;
    localparam logic [15:0]   WD_MAX  = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [logn:0]   rd_cnt;
    logic [logn:0]   wr_cnt;
    logic [15:0]     wd_cnt;

    logic            capture;
    logic [logn:0]   wr_cnt_next;
    logic [15:0]     wd_next;

    // Capture decision and next values of the write counter and watchdog.
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        capture     = 1'b0;
        wr_cnt_next = wr_cnt;
        wd_next     = wd_cnt + 16'd1;
        if ((state == FEED || state == DRAIN) && fft_out_valid && (wr_cnt < N_CNT)) begin
            capture     = 1'b1;
            wr_cnt_next = wr_cnt + 1'b1;
        end
        if (fft_out_valid) begin
            wd_next = 16'd0;
        end
    end

    // Destination write port: FFT results pass straight through while capturing.
    always_comb begin
        dst_wr_en = capture;
        dst_addr  = '0;
        dst_re    = '0;
        dst_im    = '0;
        if (capture) begin
            dst_addr = wr_cnt[logn-1:0];
            dst_re   = fft_fo_re;
            dst_im   = fft_fo_im;
        end
    end

    // Feed path: source data arrives one cycle after the read strobe, which is
    // exactly when the delayed strobe marks it valid; zero it otherwise.
    always_comb begin
        fft_fi_re = '0;
        fft_fi_im = '0;
        if (fft_in_valid) begin
            fft_fi_re = src_re;
            fft_fi_im = src_im;
        end
    end

    // Align the FFT input strobe with the one-cycle source read latency.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fft_in_valid <= 1'b0;
        end else begin
            fft_in_valid <= src_rd_en;
        end
    end

    // Frame sequencer with registered status and read-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wd_cnt    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            src_rd_en <= 1'b0;
            src_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FEED;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        rd_cnt    <= '0;
                        wr_cnt    <= '0;
                        wd_cnt    <= '0;
                        src_rd_en <= 1'b1;
                        src_addr  <= '0;
                    end
                end

                FEED: begin
                    // The read at address rd_cnt is on the port this cycle.
                    rd_cnt <= rd_cnt + 1'b1;
                    wr_cnt <= wr_cnt_next;
                    if (rd_cnt == LAST_RD) begin
                        state     <= DRAIN;
                        src_rd_en <= 1'b0;
                        src_addr  <= '0;
                        wd_cnt    <= '0;
                    end else begin
                        src_addr <= rd_cnt[logn-1:0] + 1'b1;
                    end
                end

                DRAIN: begin
                    wr_cnt <= wr_cnt_next;
                    wd_cnt <= wd_next;
                    // A completing write takes priority over the watchdog.
                    if (wr_cnt_next == N_CNT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (wd_next == WD_MAX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    src_rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl. A stub FFT with configurable
// latency and output pattern sits between the feed and capture ports.
// Expected reads, feed samples and destination writes are queued when the
// stimulus creates them; a negedge monitor pops and compares them.
module tb_fft_frame_ctrl;

    localparam int FP      = 64;
    localparam int LOGN    = 8;
    localparam int N       = 256;
    localparam int TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic          src_rd_en;
    logic [LOGN-1:0] src_addr;
    logic [FP-1:0] src_re = '0, src_im = '0;
    logic          fft_in_valid;
    logic [FP-1:0] fft_fi_re, fft_fi_im;
    logic          fft_out_valid = 1'b0;
    logic [FP-1:0] fft_fo_re = '0, fft_fo_im = '0;
    logic          dst_wr_en;
    logic [LOGN-1:0] dst_addr;
    logic [FP-1:0] dst_re, dst_im;

    fft_frame_ctrl #(.FLOAT_PRECISION(FP), .logn(LOGN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_re(src_re), .src_im(src_im),
        .fft_in_valid(fft_in_valid), .fft_fi_re(fft_fi_re), .fft_fi_im(fft_fi_im),
        .fft_out_valid(fft_out_valid), .fft_fo_re(fft_fo_re), .fft_fo_im(fft_fo_im),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_re(dst_re), .dst_im(dst_im)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [63:0] re;
        logic [63:0] im;
    } exp_t;

    typedef struct {
        int          rdy;
        logic [63:0] re;
        logic [63:0] im;
    } pend_t;

    exp_t  rd_q[$];
    exp_t  fin_q[$];
    exp_t  wr_q[$];
    pend_t pend[$];

    int checks = 0;
    int errors = 0;

    // Stub configuration: 0 fixed latency, 1 bursty, 2 stall after 100, 3 surplus.
    int   mode = 0;
    int   lat = 20;
    int   emit_idx = 0;
    int   extra_left = 0;
    int   last_emit = -1;
    int   w_last = -1;
    int   tag = 0;
    logic prev_rd = 1'b0;
    logic [7:0] prev_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: DUT strobe with no expected item", name, cyc);
    endtask

    function automatic logic [63:0] src_word(input int t, input int a);
        return 64'h5A00_0000_0000_0000 ^ (64'(t) << 40) ^ (64'(a) * 64'h0001_0001_0001);
    endfunction

    // Monitor: compare every DUT strobe against the head of its queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        prev_rd   = src_rd_en;
        prev_addr = src_addr;
        if (src_rd_en) begin
            if (rd_q.size() == 0) unexpected("rd_extra");
            else begin
                e = rd_q.pop_front();
                check("rd_cycle", 64'(cyc), 64'(e.cyc));
                check("rd_addr", 64'(src_addr), 64'(e.addr));
            end
        end
        if (fft_in_valid) begin
            if (fin_q.size() == 0) unexpected("feed_extra");
            else begin
                e = fin_q.pop_front();
                check("feed_cycle", 64'(cyc), 64'(e.cyc));
                check("feed_re", fft_fi_re, e.re);
                check("feed_im", fft_fi_im, e.im);
            end
            pend.push_back('{cyc + lat, fft_fi_re + 64'd1, fft_fi_im ^ 64'hFFFF_0000_FFFF_0000});
        end else begin
            check("feed_idle_zero", fft_fi_re | fft_fi_im, 64'd0);
        end
        if (dst_wr_en) begin
            if (wr_q.size() == 0) unexpected("wr_extra");
            else begin
                e = wr_q.pop_front();
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
                check("wr_addr", 64'(dst_addr), 64'(e.addr));
                check("wr_re", dst_re, e.re);
                check("wr_im", dst_im, e.im);
            end
        end
    end

    // Driver: source buffer with one-cycle read latency, plus the FFT stub.
    initial forever begin
        pend_t p;
        @(posedge clk);
        #1;
        src_re = prev_rd ? src_word(tag, int'(prev_addr)) : 64'hBAD0_BAD0_BAD0_BAD0;
        src_im = prev_rd ? ~src_word(tag, int'(prev_addr)) : 64'h0BAD_0BAD_0BAD_0BAD;
        fft_out_valid = 1'b0;
        fft_fo_re = '0;
        fft_fo_im = '0;
        if (pend.size() > 0 && pend[0].rdy <= cyc && (mode != 1 || cyc % 2 == 0) &&
            (mode != 2 || emit_idx < 100)) begin
            p = pend.pop_front();
            fft_out_valid = 1'b1;
            fft_fo_re = p.re;
            fft_fo_im = p.im;
            if (emit_idx < N) wr_q.push_back('{cyc, 8'(emit_idx), p.re, p.im});
            last_emit = cyc;
            emit_idx++;
            if (emit_idx == N) w_last = cyc;
        end else if (mode == 3 && pend.size() == 0 && emit_idx >= N && extra_left > 0) begin
            extra_left--;
            fft_out_valid = 1'b1;
            fft_fo_re = 64'hDEAD_BEEF_DEAD_BEEF;
            fft_fo_im = 64'h1234_5678_9ABC_DEF0;
        end
    end

    // Issue start in the current cycle (called at posedge+1) and queue the
    // expected reads (cycles s+1..s+N) and feed samples (cycles s+2..s+N+1).
    task automatic launch(input int m, input int l, output int s);
        mode = m;
        lat = l;
        pend.delete();
        emit_idx = 0;
        extra_left = 4;
        last_emit = -1;
        w_last = -1;
        tag++;
        start = 1'b1;
        s = cyc;
        for (int i = 0; i < N; i++) begin
            rd_q.push_back('{s + 1 + i, 8'(i), 64'd0, 64'd0});
            fin_q.push_back('{s + 2 + i, 8'(i), src_word(tag, i), ~src_word(tag, i)});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_in_feed", 64'(busy), 64'd1);
        check("error_cleared", 64'(error), 64'd0);
    endtask

    // Wait for done (bounded) and compare its cycle and status. DRAIN begins
    // at s+N+1; done lands the cycle after the last write (or after the
    // first DRAIN cycle if writes finished earlier), or TIMEOUT idle DRAIN
    // cycles after the last valid when stalled.
    task automatic wait_done(input int s, input bit stall, input bit pulse_start);
        int budget = 4000;
        int d = s + N + 1;
        int exp_cyc;
        do begin
            @(posedge clk);
            #2;
            budget--;
        end while (!done && budget > 0);
        if (!done) begin
            unexpected("done_timeout");
            return;
        end
        if (pulse_start) start = 1'b1;
        if (stall) exp_cyc = ((last_emit + 1 > d) ? last_emit + 1 : d) + TIMEOUT;
        else       exp_cyc = ((w_last > d) ? w_last : d) + 1;
        check("done_cycle", 64'(cyc), 64'(exp_cyc));
        check("done_error", 64'(error), stall ? 64'd1 : 64'd0);
        check("done_busy", 64'(busy), 64'd0);
    endtask

    task automatic end_frame();
        repeat (10) @(posedge clk);
        #2;
        check("done_single_pulse", 64'(done), 64'd0);
        check("rd_left", 64'(rd_q.size()), 64'd0);
        check("feed_left", 64'(fin_q.size()), 64'd0);
        check("wr_left", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s;
        // Reset state.
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_rd_en", 64'(src_rd_en), 64'd0);
        check("rst_in_valid", 64'(fft_in_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Nominal frame, fixed latency 20.
        launch(0, 20, s);
        wait_done(s, 1'b0, 1'b0);
        end_frame();

        // Bursty output: valid on even cycles only.
        @(posedge clk); #1;
        launch(1, 20, s);
        wait_done(s, 1'b0, 1'b0);
        end_frame();

        // start during FEED and during DONE ignored; start in next IDLE accepted.
        @(posedge clk); #1;
        launch(0, 20, s);
        while (cyc < s + 50) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(s, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("done_dropped", 64'(done), 64'd0);
        launch(0, 20, s);
        wait_done(s, 1'b0, 1'b0);
        end_frame();

        // Stall after 100 outputs (late enough to fall in DRAIN), then recover.
        @(posedge clk); #1;
        launch(2, 300, s);
        wait_done(s, 1'b1, 1'b0);
        end_frame();
        check("error_sticky", 64'(error), 64'd1);
        @(posedge clk); #1;
        launch(0, 20, s);
        wait_done(s, 1'b0, 1'b0);
        end_frame();

        // Surplus outputs beyond N are not written.
        @(posedge clk); #1;
        launch(3, 20, s);
        wait_done(s, 1'b0, 1'b0);
        end_frame();

        // Asynchronous reset mid-FEED with address 50 on the read port.
        @(posedge clk); #1;
        launch(0, 20, s);
        while (cyc < s + 51) @(posedge clk);
        #1;
        check("pre_rst_addr", 64'(src_addr), 64'd50);
        #2;
        rst_n = 1'b0;
        rd_q.delete();
        fin_q.delete();
        wr_q.delete();
        pend.delete();
        mode = 0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_rd_en", 64'(src_rd_en), 64'd0);
        check("arst_addr", 64'(src_addr), 64'd0);
        check("arst_in_valid", 64'(fft_in_valid), 64'd0);
        check("arst_fi", fft_fi_re | fft_fi_im, 64'd0);
        check("arst_wr_en", 64'(dst_wr_en), 64'd0);
        check("arst_dst", dst_re | dst_im | 64'(dst_addr), 64'd0);
        check("arst_done_err", 64'({done, error}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        launch(0, 20, s);
        wait_done(s, 1'b0, 1'b0);
        end_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer for the 3-stage radix-2 FFT pipeline.
- On `start`, reads one frame of N = 2^logn complex samples from a source buffer and streams them into the FFT, one per cycle, with `in_valid`.
- Captures the FFT output stream into a destination buffer in arrival order and signals `done` when N results are stored.
- Provides a drain watchdog so a stalled pipeline cannot hang the controller.

Parameters:
- FLOAT_PRECISION, 64, width of each real/imag sample word.
- logn, 8, log2 of frame length N; source/destination addresses are logn bits.
- TIMEOUT, 1024, max cycles without `fft_out_valid` in DRAIN before abort; counter is 16 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request; honoured only in IDLE.
- busy  out  1  high in FEED and DRAIN.
- done  out  1  one-cycle pulse at frame end (normal or aborted).
- error  out  1  sticky timeout flag; cleared by the next accepted start.
- src_rd_en  out  1  source buffer read strobe.
- src_addr  out  logn  source read address.
- src_re, src_im  in  FLOAT_PRECISION  source read data, valid 1 cycle after `src_rd_en`.
- fft_in_valid  out  1  to FFT `in_valid`.
- fft_fi_re, fft_fi_im  out  FLOAT_PRECISION  to FFT `fi_re`/`fi_im`.
- fft_out_valid  in  1  from FFT `out_valid`.
- fft_fo_re, fft_fo_im  in  FLOAT_PRECISION  from FFT `fo_re`/`fo_im`.
- dst_wr_en  out  1  destination write strobe.
- dst_addr  out  logn  destination write address.
- dst_re, dst_im  out  FLOAT_PRECISION  destination write data.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, all counters 0, `error` 0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 -> FEED next cycle; clear `error`, `rd_cnt`, `wr_cnt`.
  - `start` is ignored in every other state, including DONE.
- FEED:
  - `src_rd_en`=1 every cycle; `src_addr` = `rd_cnt` (0..N-1), `rd_cnt` increments.
  - After the read with address N-1 -> DRAIN.
  - Exactly N reads, no gaps.
- Feed path, all states:
  - `fft_in_valid` = `src_rd_en` delayed 1 cycle.
  - `fft_fi_re`/`fft_fi_im` = `src_re`/`src_im` (combinational pass of 1-cycle-latency data).
  - When `fft_in_valid`=0, `fft_fi_*` outputs are 0.
- Capture, FEED and DRAIN:
  - Each cycle `fft_out_valid`=1 and `wr_cnt`<N: `dst_wr_en`=1, `dst_addr`=`wr_cnt`, `dst_*`=`fft_fo_*` (combinational); `wr_cnt` increments.
  - Gaps in `fft_out_valid` are tolerated; addresses stay contiguous.
  - `fft_out_valid` beyond N, or in IDLE/DONE, is ignored (no write).
- DRAIN:
  - Watchdog counter increments each cycle without `fft_out_valid`; resets to 0 on any valid.
  - `wr_cnt` reaches N -> DONE.
  - Watchdog reaches TIMEOUT -> `error`=1, DONE.
  - If the last write and the timeout occur in the same cycle, the write wins: `error` stays 0.
- Capture can complete during FEED only if N writes land before the last read. That is impossible for pipeline latency ≥1. FEED always goes to DRAIN first; DRAIN exits to DONE in its first cycle if `wr_cnt`=N.
- DONE: `done`=1 for exactly one cycle, `busy`=0 -> IDLE.
- `busy` = (state==FEED or state==DRAIN), registered with the state.
- Counters: `rd_cnt` and `wr_cnt` are logn+1 bits (to hold N); addresses are their low logn bits.
- Latency from `start` to first `fft_in_valid`: 2 cycles.

Test Plan:
- Nominal frame, logn=8, FFT stub with fixed latency 20, `start` at cycle 0:
  - `src_rd_en` cycles 1..256, `src_addr` 0..255.
  - `fft_in_valid` cycles 2..257.
  - 256 writes to `dst_addr` 0..255, data matches stub, `done` pulse once, `error`=0.
- Bursty output: stub alternates `fft_out_valid` 1/0 -> writes still land at addresses 0..255 in order; `done` after the 256th write.
- `start` asserted during FEED and again in the DONE cycle -> ignored (`src_addr` sequence unbroken, no second frame); `start` in the following IDLE cycle launches frame 2.
- Stall: stub emits 100 outputs then stops, TIMEOUT=1024 -> `done` pulses 1024 cycles after the last valid, `error`=1; next `start` clears `error`.
- Surplus outputs: stub emits 260 valids -> only 256 writes, extras produce no `dst_wr_en`.
- Async reset mid-FEED (`rd_cnt`=50) -> all outputs 0 immediately, state IDLE after release; a fresh `start` runs a complete correct frame.
